// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types, defaults and helpers for the shared multiplier arbiter
package mul_share_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r with 2^r >= v; used to size IDs and iteration counters.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_seq_core.sv
// rtl/mul_seq_core.sv - sequential shift-add multiplier, signed x by unsigned y
module mul_seq_core
    import mul_share_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = (W > 1) ? clog2(W) : 1;

    logic [2*W-1:0] acc;
    logic [2*W-1:0] t;
    logic [W-1:0]   y_reg;
    logic [CW-1:0]  count;
    logic           run;

    // done marks the edge that performs the final iteration
    assign done = run && (count == CW'(W - 1));
    assign p    = acc;

    // Load on start, then one add/shift per edge; x is sign-extended so the product wraps mod 2^(2W)
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            t     <= '0;
            y_reg <= '0;
            count <= '0;
            run   <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            t     <= {{W{x[W-1]}}, x};
            y_reg <= y;
            count <= '0;
            run   <= 1'b1;
        end else if (run) begin
            if (y_reg[0]) begin
                acc <= acc + t;
            end
            y_reg <= y_reg >> 1;
            t     <= t << 1;
            count <= count + 1'b1;
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin arbiter time-sharing one shift-add multiplier
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] x_in,
    input  logic [N_REQ*W-1:0] y_in,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic [2*W-1:0]     p_out,
    output logic               p_valid,
    output logic [ID_W-1:0]    p_id
);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic            start;
    logic            core_done;
    logic [2*W-1:0]  core_p;
    logic [W-1:0]    x_sel;
    logic [W-1:0]    y_sel;

    // First set request searching upward from last+1 with wrap; returns {found, index}.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  l);
        logic [ID_W:0]    res;
        logic [N_REQ-1:0] shifted;
        int               idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx     = (int'(l) + k) % N_REQ;
            shifted = r >> idx;
            if (shifted[0]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    // Winner selection and operand mux feeding the core
    always_comb begin
        {pick_found, pick_idx} = rr_pick(req, last);
        x_sel = W'(x_in >> (int'(pick_idx) * W));
        y_sel = W'(y_in >> (int'(pick_idx) * W));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and core start strobe
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    start      = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (core_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, winner tracking and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            busy    <= 1'b0;
            p_valid <= 1'b0;
            p_out   <= '0;
            p_id    <= '0;
            winner  <= '0;
            last    <= ID_W'(N_REQ - 1);
        end else begin
            grant   <= '0;
            p_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant  <= N_REQ'(1) << pick_idx;
                        busy   <= 1'b1;
                        winner <= pick_idx;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DONE: begin
                    p_out   <= core_p;
                    p_id    <= winner;
                    p_valid <= 1'b1;
                    last    <= winner;
                end
                default: begin
                end
            endcase
        end
    end

    mul_seq_core #(
        .W (W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x_sel),
        .y     (y_sel),
        .done  (core_done),
        .p     (core_p)
    );

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - self-checking bench for the shared multiplier arbiter
module tb_mul_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  xs [4];
    logic [7:0]  ys [4];
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] p_out;
    logic        p_valid;
    logic [1:0]  p_id;

    typedef struct {
        int          id;
        logic [15:0] p;
        int          gcyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_gcyc = 0;

    assign x_in = {xs[3], xs[2], xs[1], xs[0]};
    assign y_in = {ys[3], ys[2], ys[1], ys[0]};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_share_arb #(
        .N_REQ (4),
        .W     (8),
        .ID_W  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .x_in    (x_in),
        .y_in    (y_in),
        .grant   (grant),
        .busy    (busy),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_id    (p_id)
    );

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] xe;
        xe = {{8{x[7]}}, x};
        return xe * {8'h00, y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every p_valid
    always @(negedge clk) begin
        if (p_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_p_valid", {31'b0, p_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("p_out", {16'b0, p_out}, {16'b0, e.p});
                chk("p_id", {30'b0, p_id}, e.id);
                chk("latency", cyc - e.gcyc, 32'd9);
                chk("busy_at_p_valid", {31'b0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_grant(input int idx, input int gap);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant !== 4'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("grant_seen", {31'b0, found}, 32'd1);
        if (found) begin
            chk($sformatf("grant_%0d", idx), {28'b0, grant}, {28'b0, 4'b0001 << idx});
            if (gap >= 0) begin
                chk("grant_gap", cyc - last_gcyc, gap);
            end
            last_gcyc = cyc;
            sb.push_back(exp_t'{idx, model(xs[idx], ys[idx]), cyc});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_single(input int id, input logic [7:0] x, input logic [7:0] y,
                             input logic [15:0] exp);
        xs[id] = x;
        ys[id] = y;
        req = 4'b0001 << id;
        wait_grant(id, -1);
        req = 4'b0;
        @(negedge clk);
        chk("grant_pulse", {28'b0, grant}, 32'd0);
        chk("busy_mid", {31'b0, busy}, 32'd1);
        drain();
        @(negedge clk);
        @(negedge clk);
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("p_out_hold", {16'b0, p_out}, {16'b0, exp});
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        req = 4'b0;
        for (int i = 0; i < 4; i++) begin
            xs[i] = 8'h00;
            ys[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_grant", {28'b0, grant}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_p_valid", {31'b0, p_valid}, 32'd0);
        chk("rst_p_out", {16'b0, p_out}, 32'd0);
        chk("rst_p_id", {30'b0, p_id}, 32'd0);
        rst = 1'b0;

        // Basic and signed/MSB coverage, one job at a time
        do_single(0, 8'h03, 8'h05, 16'h000F);
        do_single(1, 8'hFF, 8'hFF, 16'hFF01);
        do_single(2, 8'h80, 8'hFF, 16'h8080);
        do_single(3, 8'h01, 8'h80, 16'h0080);
        do_single(0, 8'h00, 8'hA5, 16'h0000);

        // Contention from reset: all four requesting
        do_reset();
        xs[0] = 8'h11; ys[0] = 8'h22;
        xs[1] = 8'hF0; ys[1] = 8'h33;
        xs[2] = 8'h7F; ys[2] = 8'h80;
        xs[3] = 8'h80; ys[3] = 8'hFF;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(k, (k == 0) ? -1 : 10);
            req[k] = 1'b0;
        end
        drain();

        // Fairness: requesters 0 and 2 held continuously
        do_reset();
        xs[0] = 8'hC3; ys[0] = 8'h5A;
        xs[2] = 8'h25; ys[2] = 8'hE7;
        req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            wait_grant((k % 2) * 2, (k == 0) ? -1 : 10);
        end
        req = 4'b0;
        drain();

        // Reset during the fourth MUL cycle
        do_single(1, 8'h07, 8'h09, 16'h003F);
        xs[0] = 8'h55; ys[0] = 8'h66;
        req = 4'b0001;
        wait_grant(0, -1);
        req = 4'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_grant", {28'b0, grant}, 32'd0);
        chk("abort_p_valid", {31'b0, p_valid}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (p_valid === 1'b1) seen++;
        end
        chk("abort_no_p_valid", seen, 32'd0);
        xs[1] = 8'h9C; ys[1] = 8'h0D;
        xs[3] = 8'h40; ys[3] = 8'hC8;
        req = 4'b1010;
        wait_grant(1, -1);
        req[1] = 1'b0;
        wait_grant(3, 10);
        req = 4'b0;
        drain();

        // Late req drop: requester 0 repeats, then requester 1 goes before it
        do_reset();
        xs[0] = 8'h12; ys[0] = 8'h34;
        xs[1] = 8'hEE; ys[1] = 8'h81;
        req = 4'b0001;
        wait_grant(0, -1);
        wait_grant(0, 10);
        req[1] = 1'b1;
        wait_grant(1, 10);
        req[1] = 1'b0;
        wait_grant(0, 10);
        req = 4'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
